consmax_lut_loader: RTL and testbench
=====================================

# consmax_lut_loader

Streams exponent/LUT coefficient words from a host-side valid/ready channel into the LUT write port of the `softmax` (ConSmax) vector-engine block. It generates `lut_waddr`/`lut_wen`/`lut_wdata` sequentially from a programmed base and length. It also produces a `lut_ready` level that the vector engine uses to hold back `idata_valid` until a complete LUT image has been written. It sits between the host configuration fabric and `softmax`, and is the write-side counterpart of the softmax LUT port.

## Interface
- `LUT_ADDR`, 9, LUT address width
- `LUT_DATA`, 16, LUT word width (bf16: sign, 8-bit exponent, 7-bit mantissa)
- `LUT_DEPTH`, 2**LUT_ADDR, number of LUT entries
- `clk` input 1 — single clock
- `rst` input 1 — reset, synchronous, active-high
- `load_start` input 1 — one-cycle pulse that begins a load
- `load_base` input LUT_ADDR — first LUT address, sampled on `load_start`
- `load_len` input LUT_ADDR+1 — word count, legal range 1..LUT_DEPTH, sampled on `load_start`
- `load_abort` input 1 — terminates an active load
- `in_data` input LUT_DATA — host word
- `in_valid` input 1 — host word valid
- `in_ready` output 1 — loader accepts a word
- `lut_waddr` output LUT_ADDR — to `softmax`
- `lut_wen` output 1 — to `softmax`
- `lut_wdata` output LUT_DATA — to `softmax`
- `busy` output 1 — load in progress
- `done` output 1 — one-cycle pulse on the final write
- `err` output 1 — one-cycle pulse on an illegal command
- `lut_ready` output 1 — a complete, valid LUT image is resident

## Operation
- FSM states: IDLE, LOAD.
- **IDLE**
  - On `load_start` with `load_len` in 1..LUT_DEPTH: latch base and length, clear the counter, clear `lut_ready`, go to LOAD.
  - On `load_start` with `load_len` = 0 or `load_len` > LUT_DEPTH: pulse `err`, stay in IDLE, leave `lut_ready` unchanged.
- **LOAD**
  - `in_ready` = 1 for the whole state.
  - On each handshake (`in_valid && in_ready`), in the next cycle: `lut_wen`=1, `lut_waddr`=(base+count) mod LUT_DEPTH, `lut_wdata`=`in_data`; the counter then increments.
  - When the handshake for word `load_len`-1 occurs, the FSM returns to IDLE in the next cycle. That same cycle carries the last write, `done`=1, and `lut_ready`=1.
- **Abort:** `load_abort` in LOAD returns the FSM to IDLE in the next cycle.
  - A handshake in the abort cycle is still written.
  - No `done` pulse; `lut_ready` stays 0.
  - `load_abort` in IDLE is ignored.
- **Start while busy:** `load_start` in LOAD is ignored and pulses `err`; the active load continues.
- **Priority:** `rst` > `load_abort` > completion > handshake.
- **Address wrap:** addresses wrap modulo LUT_DEPTH. Example: base 510, len 4 writes addresses 510, 511, 0, 1.

## Timing
- All outputs are registered except `in_ready`, which decodes directly from the state register.
- Handshake to `lut_wen`: latency 1 cycle. Throughput is 1 word/cycle.
- `load_start` to `in_ready`=1: 1 cycle.
- `busy` = 1 from the cycle after an accepted `load_start` through the cycle of the last handshake. It is 0 in the `done` cycle.
- Reset values: FSM=IDLE, `in_ready`=0, `lut_wen`=0, `lut_waddr`=0, `lut_wdata`=0, `busy`=0, `done`=0, `err`=0, `lut_ready`=0.
- `rst` asserted mid-load: next cycle all outputs take their reset values, the write pipeline is flushed, and no pending write is issued.
- `lut_waddr`/`lut_wdata` hold their last values when `lut_wen`=0.

## Configuration
- Macro: `CONSMAX_LUT_CHECKSUM_EN`.
- **Defined**
  - Adds input `load_sum` [LUT_DATA-1:0], sampled on `load_start`.
  - Adds output `sum_err` (1 bit, reset 0).
  - A running sum mod 2^LUT_DATA accumulates every word written.
  - In the `done` cycle: if sum ≠ `load_sum`, `sum_err` pulses 1 and `lut_ready` stays 0; otherwise `lut_ready`=1.
  - The sum clears on every accepted `load_start`.
- **Undefined:** neither port exists, and `lut_ready` sets on every completion.

## Test plan
- **Full load:** `load_start`, base 0, len 512, `in_valid` held 1, data = address ^ 16'hA5A5 → 512 consecutive `lut_wen` cycles at addresses 0..511 with matching data; `done` and `lut_ready` rise with the address-511 write.
- **Wrap + backpressure:** base 510, len 4, `in_valid` toggling 1/0 → writes to 510, 511, 0, 1 only, each 1 cycle after its handshake; `done` with the address-1 write.
- **Illegal commands:** len 0 → `err` pulse, FSM stays IDLE; len 513 → `err`; `load_start` during LOAD → `err` and the load completes unchanged.
- **Abort:** len 8, `load_abort` after 3 handshakes with `in_valid`=1 in the abort cycle → exactly 4 writes, no `done`, `lut_ready`=0, `in_ready`=0 next cycle.
- **Reset mid-load:** `rst` after 5 handshakes → next cycle all outputs 0, no further `lut_wen`; a new len-2 load then completes normally.
- **Checksum (macro defined):** len 3, data 1, 2, 3, `load_sum` 6 → `lut_ready`=1, `sum_err`=0; repeat with `load_sum` 7 → `sum_err` pulse, `lut_ready`=0.

Source files
------------

// File: rtl/consmax_lut_loader.sv
// Streams host coefficient words into the softmax LUT write port and flags when a full image is resident.
// Optional feature macro: CONSMAX_LUT_CHECKSUM_EN adds a per-load checksum (load_sum in, sum_err out).
module consmax_lut_loader #(
    parameter int LUT_ADDR  = 9,
    parameter int LUT_DATA  = 16,
    parameter int LUT_DEPTH = 2**LUT_ADDR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic [LUT_ADDR-1:0] load_base,
    input  logic [LUT_ADDR:0]   load_len,
    input  logic                load_abort,
    input  logic [LUT_DATA-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [LUT_ADDR-1:0] lut_waddr,
    output logic                lut_wen,
    output logic [LUT_DATA-1:0] lut_wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
`ifdef CONSMAX_LUT_CHECKSUM_EN
    input  logic [LUT_DATA-1:0] load_sum,
    output logic                sum_err,
`endif
    output logic                lut_ready
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    localparam logic [LUT_ADDR:0] DEPTH_W = (LUT_ADDR+1)'(LUT_DEPTH);

    state_t              state_q, state_d;
    logic [LUT_ADDR-1:0] base_q, base_d;
    logic [LUT_ADDR:0]   len_q, len_d;
    logic [LUT_ADDR:0]   count_q, count_d;
    logic [LUT_ADDR-1:0] waddr_q, waddr_d;
    logic [LUT_DATA-1:0] wdata_q, wdata_d;
    logic                wen_q, wen_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                lut_ready_q, lut_ready_d;
    logic                hs_s;
    logic                last_s;
    logic                len_ok_s;
    logic                image_ok_s;
`ifdef CONSMAX_LUT_CHECKSUM_EN
    logic [LUT_DATA-1:0] sum_q, sum_d;
    logic [LUT_DATA-1:0] sum_ref_q, sum_ref_d;
    logic                sum_err_q, sum_err_d;
`endif

    assign in_ready  = (state_q == ST_LOAD);
    assign lut_waddr = waddr_q;
    assign lut_wen   = wen_q;
    assign lut_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign lut_ready = lut_ready_q;
`ifdef CONSMAX_LUT_CHECKSUM_EN
    assign sum_err   = sum_err_q;
`endif

    // Next-state, write-port and status computation
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        count_d     = count_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        wen_d       = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        lut_ready_d = lut_ready_q;
        hs_s        = in_valid && (state_q == ST_LOAD);
        last_s      = (count_q == (len_q - {{LUT_ADDR{1'b0}}, 1'b1}));
        len_ok_s    = (load_len != {(LUT_ADDR+1){1'b0}}) && (load_len <= DEPTH_W);
`ifdef CONSMAX_LUT_CHECKSUM_EN
        sum_d       = sum_q;
        sum_ref_d   = sum_ref_q;
        sum_err_d   = 1'b0;
        // The final word is still in flight, so fold it into the comparison here.
        image_ok_s  = ((sum_q + in_data) == sum_ref_q);
`else
        image_ok_s  = 1'b1;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load_start && len_ok_s) begin
                    base_d      = load_base;
                    len_d       = load_len;
                    count_d     = {(LUT_ADDR+1){1'b0}};
                    lut_ready_d = 1'b0;
                    state_d     = ST_LOAD;
`ifdef CONSMAX_LUT_CHECKSUM_EN
                    sum_d       = {LUT_DATA{1'b0}};
                    sum_ref_d   = load_sum;
`endif
                end else if (load_start) begin
                    err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                err_d = load_start;
                if (hs_s) begin
                    wen_d   = 1'b1;
                    waddr_d = base_q + count_q[LUT_ADDR-1:0];
                    wdata_d = in_data;
                    count_d = count_q + {{LUT_ADDR{1'b0}}, 1'b1};
`ifdef CONSMAX_LUT_CHECKSUM_EN
                    sum_d   = sum_q + in_data;
`endif
                end else begin
                    wen_d = 1'b0;
                end
                if (load_abort) begin
                    state_d = ST_IDLE;
                end else if (hs_s && last_s) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    lut_ready_d = image_ok_s;
`ifdef CONSMAX_LUT_CHECKSUM_EN
                    sum_err_d   = !image_ok_s;
`endif
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_LOAD);
    end

    // State and registered-output flops with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= {LUT_ADDR{1'b0}};
            len_q       <= {(LUT_ADDR+1){1'b0}};
            count_q     <= {(LUT_ADDR+1){1'b0}};
            waddr_q     <= {LUT_ADDR{1'b0}};
            wdata_q     <= {LUT_DATA{1'b0}};
            wen_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            lut_ready_q <= 1'b0;
`ifdef CONSMAX_LUT_CHECKSUM_EN
            sum_q       <= {LUT_DATA{1'b0}};
            sum_ref_q   <= {LUT_DATA{1'b0}};
            sum_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            count_q     <= count_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            lut_ready_q <= lut_ready_d;
`ifdef CONSMAX_LUT_CHECKSUM_EN
            sum_q       <= sum_d;
            sum_ref_q   <= sum_ref_d;
            sum_err_q   <= sum_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_consmax_lut_loader.sv
// Directed self-checking bench for consmax_lut_loader; the checksum scenario builds only with CONSMAX_LUT_CHECKSUM_EN.
module tb_consmax_lut_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [8:0]  load_base;
    logic [9:0]  load_len;
    logic        load_abort;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  lut_waddr;
    logic        lut_wen;
    logic [15:0] lut_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        lut_ready;
`ifdef CONSMAX_LUT_CHECKSUM_EN
    logic [15:0] load_sum;
    logic        sum_err;
`endif

    int total = 0;
    int bad   = 0;

    consmax_lut_loader dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .load_abort(load_abort), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .lut_waddr(lut_waddr), .lut_wen(lut_wen),
        .lut_wdata(lut_wdata), .busy(busy), .done(done), .err(err),
`ifdef CONSMAX_LUT_CHECKSUM_EN
        .load_sum(load_sum), .sum_err(sum_err),
`endif
        .lut_ready(lut_ready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [8:0] base, input logic [9:0] len);
        load_start = 1'b1;
        load_base  = base;
        load_len   = len;
        tick();
        load_start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; load_start = 1'b0; load_base = 9'd0; load_len = 10'd0;
        load_abort = 1'b0; in_data = 16'd0; in_valid = 1'b0;
`ifdef CONSMAX_LUT_CHECKSUM_EN
        load_sum = 16'd0;
`endif
        tick(); tick();
        total++;
        if ({in_ready, lut_wen, busy, done, err, lut_ready, lut_waddr, lut_wdata} !== 31'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {in_ready, lut_wen, busy, done, err, lut_ready, lut_waddr, lut_wdata});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_load;
        logic d;
        start_load(9'd0, 10'd512);
        total++;
        if ({in_ready, busy, lut_ready} !== 3'b110) begin
            bad++;
            $display("FAIL full_start: got %b want 110", {in_ready, busy, lut_ready});
        end
        in_valid = 1'b1;
        for (int i = 0; i < 512; i++) begin
            in_data = 16'(i) ^ 16'hA5A5;
            tick();
            d = (i == 511);
            total++;
            if ({lut_wen, done, lut_ready, busy, lut_waddr, lut_wdata} !==
                {1'b1, d, d, ~d, 9'(i), 16'(i) ^ 16'hA5A5}) begin
                bad++;
                $display("FAIL full_write[%0d]: got %h want %h", i,
                         {lut_wen, done, lut_ready, busy, lut_waddr, lut_wdata},
                         {1'b1, d, d, ~d, 9'(i), 16'(i) ^ 16'hA5A5});
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if ({lut_wen, done, lut_ready, in_ready, lut_waddr, lut_wdata} !== {4'b0010, 9'd511, 16'd511 ^ 16'hA5A5}) begin
            bad++;
            $display("FAIL full_after: got %h want %h",
                     {lut_wen, done, lut_ready, in_ready, lut_waddr, lut_wdata},
                     {4'b0010, 9'd511, 16'd511 ^ 16'hA5A5});
        end
    endtask

    task automatic test_wrap_backpressure;
        logic [8:0] exp_addr [4];
        logic d;
        exp_addr[0] = 9'd510; exp_addr[1] = 9'd511; exp_addr[2] = 9'd0; exp_addr[3] = 9'd1;
        start_load(9'd510, 10'd4);
        total++;
        if ({in_ready, lut_ready} !== 2'b10) begin
            bad++;
            $display("FAIL wrap_start: got %b want 10", {in_ready, lut_ready});
        end
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h0100 + 16'(k);
            tick();
            d = (k == 3);
            total++;
            if ({lut_wen, done, lut_ready, lut_waddr, lut_wdata} !== {1'b1, d, d, exp_addr[k], 16'h0100 + 16'(k)}) begin
                bad++;
                $display("FAIL wrap_write[%0d]: got %h want %h", k,
                         {lut_wen, done, lut_ready, lut_waddr, lut_wdata},
                         {1'b1, d, d, exp_addr[k], 16'h0100 + 16'(k)});
            end
            in_valid = 1'b0;
            in_data  = 16'hDEAD;
            tick();
            total++;
            if ({lut_wen, done, lut_waddr, lut_wdata} !== {2'b00, exp_addr[k], 16'h0100 + 16'(k)}) begin
                bad++;
                $display("FAIL wrap_idle[%0d]: got %h want %h", k,
                         {lut_wen, done, lut_waddr, lut_wdata}, {2'b00, exp_addr[k], 16'h0100 + 16'(k)});
            end
        end
    endtask

    task automatic test_illegal;
        start_load(9'd3, 10'd0);
        total++;
        if ({err, in_ready, busy, lut_ready} !== 4'b1001) begin
            bad++;
            $display("FAIL illegal_len0: got %b want 1001", {err, in_ready, busy, lut_ready});
        end
        tick();
        total++;
        if ({err, in_ready} !== 2'b00) begin
            bad++;
            $display("FAIL illegal_err_pulse: got %b want 00", {err, in_ready});
        end
        start_load(9'd3, 10'd513);
        total++;
        if ({err, in_ready, busy, lut_ready} !== 4'b1001) begin
            bad++;
            $display("FAIL illegal_len513: got %b want 1001", {err, in_ready, busy, lut_ready});
        end
        start_load(9'd5, 10'd2);
        in_valid = 1'b1; in_data = 16'h0011;
        load_start = 1'b1; load_base = 9'd300; load_len = 10'd7;
        tick();
        load_start = 1'b0;
        total++;
        if ({err, lut_wen, done, lut_waddr, lut_wdata} !== {3'b110, 9'd5, 16'h0011}) begin
            bad++;
            $display("FAIL start_busy_err: got %h want %h",
                     {err, lut_wen, done, lut_waddr, lut_wdata}, {3'b110, 9'd5, 16'h0011});
        end
        in_data = 16'h0022;
        tick();
        in_valid = 1'b0;
        total++;
        if ({err, lut_wen, done, lut_ready, lut_waddr, lut_wdata} !== {4'b0111, 9'd6, 16'h0022}) begin
            bad++;
            $display("FAIL start_busy_complete: got %h want %h",
                     {err, lut_wen, done, lut_ready, lut_waddr, lut_wdata}, {4'b0111, 9'd6, 16'h0022});
        end
    endtask

    task automatic test_abort;
        int nwr = 0;
        start_load(9'd20, 10'd8);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data    = 16'h0A00 + 16'(i);
            load_abort = (i == 3);
            tick();
            if (lut_wen) nwr++;
        end
        load_abort = 1'b0;
        total++;
        if ({lut_wen, done, lut_ready, in_ready, busy, lut_waddr, lut_wdata} !== {5'b10000, 9'd23, 16'h0A03}) begin
            bad++;
            $display("FAIL abort_cycle: got %h want %h",
                     {lut_wen, done, lut_ready, in_ready, busy, lut_waddr, lut_wdata}, {5'b10000, 9'd23, 16'h0A03});
        end
        tick();
        if (lut_wen) nwr++;
        in_valid = 1'b0;
        total++;
        if ({lut_wen, done, lut_ready, in_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL abort_after: got %b want 0000", {lut_wen, done, lut_ready, in_ready});
        end
        total++;
        if (nwr != 4) begin
            bad++;
            $display("FAIL abort_write_count: got %0d want 4", nwr);
        end
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        total++;
        if ({lut_wen, in_ready, busy, err} !== 4'b0000) begin
            bad++;
            $display("FAIL abort_idle_ignored: got %b want 0000", {lut_wen, in_ready, busy, err});
        end
    endtask

    task automatic test_reset_mid_load;
        start_load(9'd100, 10'd10);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'h0B00 + 16'(i);
            tick();
        end
        in_data = 16'h0B05;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({in_ready, lut_wen, busy, done, err, lut_ready, lut_waddr, lut_wdata} !== 31'd0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got %h want 0",
                     {in_ready, lut_wen, busy, done, err, lut_ready, lut_waddr, lut_wdata});
        end
        tick();
        in_valid = 1'b0;
        total++;
        if ({lut_wen, in_ready} !== 2'b00) begin
            bad++;
            $display("FAIL rst_mid_no_write: got %b want 00", {lut_wen, in_ready});
        end
        start_load(9'd7, 10'd2);
        in_valid = 1'b1; in_data = 16'h00AA;
        tick();
        total++;
        if ({lut_wen, done, lut_waddr, lut_wdata} !== {2'b10, 9'd7, 16'h00AA}) begin
            bad++;
            $display("FAIL rst_reload_w0: got %h want %h",
                     {lut_wen, done, lut_waddr, lut_wdata}, {2'b10, 9'd7, 16'h00AA});
        end
        in_data = 16'h00BB;
        tick();
        in_valid = 1'b0;
        total++;
        if ({lut_wen, done, lut_ready, lut_waddr, lut_wdata} !== {3'b111, 9'd8, 16'h00BB}) begin
            bad++;
            $display("FAIL rst_reload_w1: got %h want %h",
                     {lut_wen, done, lut_ready, lut_waddr, lut_wdata}, {3'b111, 9'd8, 16'h00BB});
        end
    endtask

`ifdef CONSMAX_LUT_CHECKSUM_EN
    task automatic test_checksum;
        for (int r = 0; r < 2; r++) begin
            load_sum = (r == 0) ? 16'd6 : 16'd7;
            start_load(9'd0, 10'd3);
            in_valid = 1'b1;
            for (int i = 1; i <= 3; i++) begin
                in_data = 16'(i);
                tick();
            end
            in_valid = 1'b0;
            total++;
            if ({done, lut_ready, sum_err} !== ((r == 0) ? 3'b110 : 3'b101)) begin
                bad++;
                $display("FAIL checksum[%0d]: got %b want %b", r, {done, lut_ready, sum_err},
                         (r == 0) ? 3'b110 : 3'b101);
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_wrap_backpressure();
        test_illegal();
        test_abort();
        test_reset_mid_load();
`ifdef CONSMAX_LUT_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
